i2c_sfp_access: RTL and testbench
=================================

# i2c_sfp_access

Parametrised I2C access sequencer for FMC-mounted SFP transceivers; successor to the read-only SFP EEPROM reader. Selects a PCA9548A switch channel, performs a multi-byte read or write to the SFP EEPROM (A0h MSA or A2h diagnostics page), then always deselects the switch. It adds per-byte retry, a wait timeout and error codes, and sits between the slow-control register file and the shared I2C byte controller.

## Interface
Parameters:
- MAX_BYTES, 16, largest transfer length; rd_data/wr_data are 8*MAX_BYTES wide
- RETRIES, 2, extra attempts per byte after an error or timeout
- TIMEOUT_CYC, 250000, cycles allowed per byte wait (2 ms at 125 MHz)

Ports (NB = $clog2(MAX_BYTES+1)):
- clk  in  1  125-MHz clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; ignored while busy
- rw  in  1  0 = read, 1 = write
- fmc_loc  in  2  switch address bits A1:A0
- mux_chan  in  3  switch channel, encoded as a one-hot control byte
- map_sel  in  1  0 = A0h page, 1 = A2h page
- start_adr  in  8  first EEPROM register
- num_bytes  in  NB  transfer length, 1..MAX_BYTES
- wr_data  in  8*MAX_BYTES  write bytes; byte i at [8i+7:8i]
- rd_data  out  8*MAX_BYTES  read bytes; byte i at [8i+7:8i]
- busy  out  1  high from the cycle after an accepted start through done/error
- done  out  1  one-cycle success pulse
- error  out  1  one-cycle failure pulse
- err_code  out  2  0 none, 1 bad request, 2 transfer failed, 3 deselect failed
- i2c_op  out  2  0 switch write, 1 register read, 2 register write
- i2c_dev_adr  out  8  {7-bit address, 0}
- i2c_reg_adr  out  8  switch control byte, or EEPROM register
- i2c_wr_dat  out  8  data byte for register write
- i2c_start  out  1  one-cycle request to the byte controller
- i2c_done  in  1  byte completed (read data valid on the same cycle)
- i2c_error  in  1  byte failed (NACK or arbitration loss)
- i2c_rd_dat  in  8  read byte

## Operation
- All inputs are captured on an accepted start.
- States and transitions:
  - IDLE → CHECK on start.
  - CHECK → FAIL with code 1 if num_bytes is 0 or greater than MAX_BYTES; no bus traffic. Otherwise → SEL.
  - SEL/SEL_W: write 1<<mux_chan to switch address {4'b1110, 0, fmc_loc}.
  - XFER/XFER_W: byte i goes to SFP address {6'b101000, map_sel}, register (start_adr + i) mod 256.
  - NEXT: increments i and goes to XFER, or to DESEL once i = num_bytes-1 completes.
  - DESEL/DESEL_W: write 00h to the switch.
  - DESEL → DONE on success, or → FAIL.
- Error or timeout in any _W state: the same byte is re-issued, up to RETRIES extra attempts. The retry counter resets on every success.
- Exhausted retries in SEL_W or XFER_W: err_code latches 2, then the block still passes through DESEL.
- A deselect failure sets code 3, but only if no earlier code is latched.
- FAIL and DONE both return to IDLE.
- Read path: rd_data is cleared on accepted start. Byte i is stored on its i2c_done. Bytes at index ≥ num_bytes read as 0. Partial data remains visible after a failure.
- Byte-controller inputs outside _W states are ignored. i2c_done and i2c_error on the same cycle count as an error.

## Timing
- Reset values: busy, done, error, i2c_start = 0; err_code, i2c_op = 0; i2c_dev_adr, i2c_reg_adr, i2c_wr_dat, rd_data = 0.
- Reset mid-operation aborts immediately; no deselect is issued.
- Start accepted at cycle 0:
  - busy = 1 at cycle 1.
  - First i2c_start at cycle 2 (bad request: error at cycle 2).
  - i2c_op, i2c_dev_adr, i2c_reg_adr and i2c_wr_dat are stable from the i2c_start cycle until i2c_done or i2c_error.
- Byte completion at cycle n → next i2c_start at n+2 (via NEXT or a retry).
- Timeout counter starts the cycle after i2c_start and expires at TIMEOUT_CYC.
- Final deselect done at cycle m → done/error pulse at m+1; busy drops at m+2.
- err_code holds until the next accepted start.

## Structure
- Package i2c_sfp_pkg holds:
  - i2c_op encodings and err_code encodings.
  - PCA9548A base address 7'b11100xx.
  - SFP addresses 7'h50 and 7'h51.
- Sub-module i2c_wait_timer: load/clear plus expiry flag, width $clog2(TIMEOUT_CYC+1).

## Test plan
- Read, num_bytes=4, start_adr=FEh, controller returns 11,22,33,44 → registers FE,FF,00,01 issued; rd_data[31:0]=44332211; done once; 6 i2c_starts total.
- Write, num_bytes=2, map_sel=1, wr_data=BBAA → register writes AAh, BBh to address A2h; then switch write 00h; done.
- Byte 1 of a read errors twice, RETRIES=2 → third attempt succeeds; done, err_code=0.
- SEL never answers, TIMEOUT_CYC=100 → 3 attempts, each timing out after 100 cycles; deselect issued; error with err_code=2.
- num_bytes=0, and separately num_bytes=17 → error at cycle 2 with err_code=1; no i2c_start.
- Reset asserted during XFER_W → all outputs at reset values next cycle; a fresh start then completes normally.

Source files
------------

// File: rtl/i2c_sfp_pkg.sv
// Shared encodings and fixed I2C addresses for the SFP access sequencer.
// Covers byte-controller opcodes, error codes, the PCA9548A switch and the SFP EEPROM pages.
package i2c_sfp_pkg;

    typedef enum logic [1:0] {
        OP_SW_WR  = 2'd0,
        OP_REG_RD = 2'd1,
        OP_REG_WR = 2'd2
    } i2c_op_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BAD_REQ = 2'd1,
        ERR_XFER    = 2'd2,
        ERR_DESEL   = 2'd3
    } err_code_e;

    // PCA9548A base; the two LSBs are the strap pins A1:A0 (A2 is tied low)
    localparam logic [6:0] PCA_BASE_ADR = 7'b1110000;
    localparam logic [6:0] SFP_A0_ADR   = 7'h50;
    localparam logic [6:0] SFP_A2_ADR   = 7'h51;

    function automatic logic [7:0] pca_dev_adr(input logic [1:0] loc);
        return {PCA_BASE_ADR[6:2], loc, 1'b0};
    endfunction

    function automatic logic [7:0] sfp_dev_adr(input logic map_sel);
        return {(map_sel ? SFP_A2_ADR : SFP_A0_ADR), 1'b0};
    endfunction

endpackage

// File: rtl/i2c_sfp_access_timer.sv
// Per-byte wait timer: cleared while a byte is issued, counts while waiting.
// The expiry flag rises on the TIMEOUT_CYC-th waiting cycle and then holds.
module i2c_wait_timer #(
    parameter int TIMEOUT_CYC = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] count_r;

    // Wait-cycle counter, saturating at its expiry value
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && (count_r != LAST)) begin
            count_r <= count_r + 1'b1;
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == LAST);

endmodule

// File: rtl/i2c_sfp_access.sv
// I2C access sequencer for FMC-mounted SFPs: select switch channel, move bytes to or
// from the EEPROM page with per-byte retry and timeout, then always deselect the switch.
module i2c_sfp_access
    import i2c_sfp_pkg::*;
#(
    parameter  int MAX_BYTES   = 16,
    parameter  int RETRIES     = 2,
    parameter  int TIMEOUT_CYC = 250000,
    localparam int NB          = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   rw,
    input  logic [1:0]             fmc_loc,
    input  logic [2:0]             mux_chan,
    input  logic                   map_sel,
    input  logic [7:0]             start_adr,
    input  logic [NB-1:0]          num_bytes,
    input  logic [8*MAX_BYTES-1:0] wr_data,
    output logic [8*MAX_BYTES-1:0] rd_data,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [1:0]             err_code,
    output logic [1:0]             i2c_op,
    output logic [7:0]             i2c_dev_adr,
    output logic [7:0]             i2c_reg_adr,
    output logic [7:0]             i2c_wr_dat,
    output logic                   i2c_start,
    input  logic                   i2c_done,
    input  logic                   i2c_error,
    input  logic [7:0]             i2c_rd_dat
);
    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_CHECK   = 4'd1;
    localparam logic [3:0] ST_SEL     = 4'd2;
    localparam logic [3:0] ST_SEL_W   = 4'd3;
    localparam logic [3:0] ST_XFER    = 4'd4;
    localparam logic [3:0] ST_XFER_W  = 4'd5;
    localparam logic [3:0] ST_NEXT    = 4'd6;
    localparam logic [3:0] ST_DESEL   = 4'd7;
    localparam logic [3:0] ST_DESEL_W = 4'd8;
    localparam logic [3:0] ST_DONE    = 4'd9;
    localparam logic [3:0] ST_FAIL    = 4'd10;

    localparam int RW = $clog2(RETRIES + 2);

    logic [3:0]             state_r;
    logic [3:0]             issue_r;
    logic                   rw_r;
    logic [1:0]             loc_r;
    logic [2:0]             chan_r;
    logic                   map_r;
    logic [7:0]             adr_r;
    logic [NB-1:0]          num_r;
    logic [8*MAX_BYTES-1:0] wdat_r;
    logic [NB-1:0]          idx_r;
    logic [RW-1:0]          retry_r;

    logic                   busy_r;
    logic                   done_r;
    logic                   error_r;
    logic [1:0]             err_code_r;
    logic [1:0]             op_r;
    logic [7:0]             dev_r;
    logic [7:0]             reg_r;
    logic [7:0]             wdt_r;
    logic                   start_r;
    logic [8*MAX_BYTES-1:0] rd_r;

    logic       wait_s;
    logic       issue_s;
    logic       expired_s;
    logic       ok_s;
    logic       fail_s;
    logic       bad_s;
    logic       last_s;
    logic       can_retry_s;
    logic       load_s;
    logic [1:0] op_s;
    logic [7:0] dev_s;
    logic [7:0] reg_s;
    logic [7:0] wdt_s;

    assign wait_s  = (state_r == ST_SEL_W) || (state_r == ST_XFER_W) || (state_r == ST_DESEL_W);
    assign issue_s = (state_r == ST_SEL) || (state_r == ST_XFER) || (state_r == ST_DESEL);

    // A simultaneous done and error is treated as an error
    assign ok_s        = wait_s && i2c_done && !i2c_error;
    assign fail_s      = wait_s && (i2c_error || (expired_s && !i2c_done));
    assign bad_s       = (num_r == {NB{1'b0}}) || (num_r > NB'(MAX_BYTES));
    assign last_s      = (idx_r == (num_r - 1'b1));
    assign can_retry_s = (int'(retry_r) < RETRIES);
    assign load_s      = ((state_r == ST_CHECK) && !bad_s) || (state_r == ST_NEXT);

    i2c_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (issue_s),
        .enable  (wait_s),
        .expired (expired_s)
    );

    // Byte-controller operands for whichever issue state is entered next
    always_comb begin
        op_s  = OP_SW_WR;
        dev_s = pca_dev_adr(loc_r);
        reg_s = 8'h00;
        wdt_s = 8'h00;
        case (issue_r)
            ST_SEL: begin
                reg_s = 8'h01 << chan_r;
            end
            ST_XFER: begin
                op_s  = rw_r ? OP_REG_WR : OP_REG_RD;
                dev_s = sfp_dev_adr(map_r);
                reg_s = adr_r + 8'(idx_r);
                wdt_s = rw_r ? wdat_r[{idx_r, 3'b000} +: 8] : 8'h00;
            end
            default: begin
                reg_s = 8'h00;
            end
        endcase
    end

    // Sequencer state, request capture, retry counting and error latching
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            issue_r    <= ST_IDLE;
            rw_r       <= 1'b0;
            loc_r      <= 2'd0;
            chan_r     <= 3'd0;
            map_r      <= 1'b0;
            adr_r      <= 8'h00;
            num_r      <= '0;
            wdat_r     <= '0;
            idx_r      <= '0;
            retry_r    <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            err_code_r <= ERR_NONE;
        end else begin
            done_r  <= 1'b0;
            error_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        rw_r       <= rw;
                        loc_r      <= fmc_loc;
                        chan_r     <= mux_chan;
                        map_r      <= map_sel;
                        adr_r      <= start_adr;
                        num_r      <= num_bytes;
                        wdat_r     <= wr_data;
                        idx_r      <= '0;
                        retry_r    <= '0;
                        issue_r    <= ST_SEL;
                        busy_r     <= 1'b1;
                        err_code_r <= ERR_NONE;
                        state_r    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (bad_s) begin
                        err_code_r <= ERR_BAD_REQ;
                        error_r    <= 1'b1;
                        state_r    <= ST_FAIL;
                    end else begin
                        state_r <= issue_r;
                    end
                end
                ST_SEL:   state_r <= ST_SEL_W;
                ST_XFER:  state_r <= ST_XFER_W;
                ST_DESEL: state_r <= ST_DESEL_W;
                ST_SEL_W, ST_XFER_W, ST_DESEL_W: begin
                    if (ok_s) begin
                        retry_r <= '0;
                        case (state_r)
                            ST_SEL_W: begin
                                idx_r   <= '0;
                                issue_r <= ST_XFER;
                                state_r <= ST_NEXT;
                            end
                            ST_XFER_W: begin
                                if (last_s) begin
                                    issue_r <= ST_DESEL;
                                end else begin
                                    idx_r   <= idx_r + 1'b1;
                                    issue_r <= ST_XFER;
                                end
                                state_r <= ST_NEXT;
                            end
                            default: begin
                                if (err_code_r == ERR_NONE) begin
                                    done_r  <= 1'b1;
                                    state_r <= ST_DONE;
                                end else begin
                                    error_r <= 1'b1;
                                    state_r <= ST_FAIL;
                                end
                            end
                        endcase
                    end else if (fail_s) begin
                        if (can_retry_s) begin
                            // issue_r still names the byte in flight, so NEXT re-issues it
                            retry_r <= retry_r + 1'b1;
                            state_r <= ST_NEXT;
                        end else if (state_r == ST_DESEL_W) begin
                            retry_r <= '0;
                            if (err_code_r == ERR_NONE) begin
                                err_code_r <= ERR_DESEL;
                            end else begin
                                err_code_r <= err_code_r;
                            end
                            error_r <= 1'b1;
                            state_r <= ST_FAIL;
                        end else begin
                            retry_r    <= '0;
                            err_code_r <= ERR_XFER;
                            issue_r    <= ST_DESEL;
                            state_r    <= ST_NEXT;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_NEXT: state_r <= issue_r;
                ST_DONE, ST_FAIL: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Byte-controller request registers, loaded on entry to an issue state
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r    <= OP_SW_WR;
            dev_r   <= 8'h00;
            reg_r   <= 8'h00;
            wdt_r   <= 8'h00;
            start_r <= 1'b0;
        end else if (load_s) begin
            op_r    <= op_s;
            dev_r   <= dev_s;
            reg_r   <= reg_s;
            wdt_r   <= wdt_s;
            start_r <= 1'b1;
        end else begin
            start_r <= 1'b0;
        end
    end

    // Read buffer: cleared on each accepted request, filled byte by byte
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_r <= '0;
        end else if ((state_r == ST_IDLE) && start) begin
            rd_r <= '0;
        end else if (ok_s && (state_r == ST_XFER_W) && !rw_r) begin
            rd_r[{idx_r, 3'b000} +: 8] <= i2c_rd_dat;
        end else begin
            rd_r <= rd_r;
        end
    end

    assign rd_data     = rd_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign error       = error_r;
    assign err_code    = err_code_r;
    assign i2c_op      = op_r;
    assign i2c_dev_adr = dev_r;
    assign i2c_reg_adr = reg_r;
    assign i2c_wr_dat  = wdt_r;
    assign i2c_start   = start_r;

endmodule

// File: tb/tb_i2c_sfp_access.sv
// Directed bench for i2c_sfp_access with a scripted byte-controller responder.
// The responder logs every i2c_start and answers per a per-request plan (ok, error, silent).
module tb_i2c_sfp_access;

    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         reset, start, rw, map_sel;
    logic [1:0]   fmc_loc;
    logic [2:0]   mux_chan;
    logic [7:0]   start_adr;
    logic [4:0]   num_bytes;
    logic [127:0] wr_data, rd_data;
    logic         busy, done, error;
    logic [1:0]   err_code, i2c_op;
    logic [7:0]   i2c_dev_adr, i2c_reg_adr, i2c_wr_dat;
    logic         i2c_start, i2c_done, i2c_error;
    logic [7:0]   i2c_rd_dat;

    i2c_sfp_access #(
        .MAX_BYTES   (16),
        .RETRIES     (2),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .rw          (rw),
        .fmc_loc     (fmc_loc),
        .mux_chan    (mux_chan),
        .map_sel     (map_sel),
        .start_adr   (start_adr),
        .num_bytes   (num_bytes),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_code    (err_code),
        .i2c_op      (i2c_op),
        .i2c_dev_adr (i2c_dev_adr),
        .i2c_reg_adr (i2c_reg_adr),
        .i2c_wr_dat  (i2c_wr_dat),
        .i2c_start   (i2c_start),
        .i2c_done    (i2c_done),
        .i2c_error   (i2c_error),
        .i2c_rd_dat  (i2c_rd_dat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0] lg_op  [0:255];
    logic [7:0] lg_dev [0:255];
    logic [7:0] lg_reg [0:255];
    logic [7:0] lg_wd  [0:255];
    int         lg_cyc [0:255];
    int         plan   [0:255];
    logic [7:0] rd_mem [0:255];
    int n_st = 0, pend = 0, act = 0;
    logic [7:0] cur_reg = 8'h00;
    int done_cnt = 0, err_cnt = 0, pulse_cyc = 0, busy_rise = 0, busy_fall = 0;
    logic busy_q = 1'b0;

    int errors = 0, checks = 0;

    // Responder and monitor: every action happens on the falling edge
    initial begin
        i2c_done = 1'b0; i2c_error = 1'b0; i2c_rd_dat = 8'h00;
        forever begin
            @(negedge clk);
            i2c_done = 1'b0; i2c_error = 1'b0;
            if (reset === 1'b1) pend = 0;
            else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    if (act == 1) i2c_error = 1'b1;
                    else begin i2c_done = 1'b1; i2c_rd_dat = rd_mem[cur_reg]; end
                end
            end
            if (i2c_start === 1'b1 && n_st < 256) begin
                lg_op[n_st] = i2c_op; lg_dev[n_st] = i2c_dev_adr;
                lg_reg[n_st] = i2c_reg_adr; lg_wd[n_st] = i2c_wr_dat; lg_cyc[n_st] = cyc;
                act = plan[n_st]; cur_reg = i2c_reg_adr;
                if (act != 2) pend = LAT;
                n_st++;
            end
            if (done === 1'b1) begin done_cnt++; pulse_cyc = cyc; end
            if (error === 1'b1) begin err_cnt++; pulse_cyc = cyc; end
            if (busy === 1'b1 && busy_q !== 1'b1) busy_rise = cyc;
            if (busy !== 1'b1 && busy_q === 1'b1) busy_fall = cyc;
            busy_q = busy;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic launch(input logic r, input logic [1:0] loc, input logic [2:0] ch,
                          input logic m, input logic [7:0] adr, input logic [4:0] nb,
                          input logic [127:0] wd, output int t0);
        @(negedge clk);
        rw = r; fmc_loc = loc; mux_chan = ch; map_sel = m;
        start_adr = adr; num_bytes = nb; wr_data = wd; start = 1'b1; t0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int d0, input int e0, output int ok);
        int k = 0;
        while (done_cnt == d0 && err_cnt == e0 && k < 2000) begin @(negedge clk); k++; end
        ok = (k < 2000) ? 1 : 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, error, i2c_start, err_code, i2c_op} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, want 00000000", {busy, done, error, i2c_start, err_code, i2c_op});
        end
        checks++;
        if ({i2c_dev_adr, i2c_reg_adr, i2c_wr_dat} !== 24'h000000) begin
            errors++;
            $display("FAIL reset_bus: got %h, want 000000", {i2c_dev_adr, i2c_reg_adr, i2c_wr_dat});
        end
        checks++;
        if (rd_data !== 128'h0) begin errors++; $display("FAIL reset_rd: got %h, want 0", rd_data); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read4();
        logic [1:0] eop  [6] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
        logic [7:0] ereg [6] = '{8'h20, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h00};
        logic [7:0] edev [6] = '{8'hE4, 8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'hE4};
        int s0, d0, e0, t0, ok;
        s0 = n_st; d0 = done_cnt; e0 = err_cnt;
        rd_mem[8'hFE] = 8'h11; rd_mem[8'hFF] = 8'h22; rd_mem[8'h00] = 8'h33; rd_mem[8'h01] = 8'h44;
        launch(1'b0, 2'd2, 3'd5, 1'b0, 8'hFE, 5'd4, 128'h0, t0);
        wait_end(d0, e0, ok);
        checks++;
        if (ok !== 1) begin errors++; $display("FAIL rd4_end: no done/error within bound, want done"); end
        checks++;
        if (busy_rise !== t0 + 1) begin errors++; $display("FAIL rd4_busy_rise: cycle %0d, want %0d", busy_rise, t0 + 1); end
        checks++;
        if (lg_cyc[s0] !== t0 + 2) begin errors++; $display("FAIL rd4_first_start: cycle %0d, want %0d", lg_cyc[s0], t0 + 2); end
        checks++;
        if (n_st - s0 !== 6) begin errors++; $display("FAIL rd4_nstart: got %0d, want 6", n_st - s0); end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (lg_op[s0+k] !== eop[k] || lg_dev[s0+k] !== edev[k] || lg_reg[s0+k] !== ereg[k]) begin
                errors++;
                $display("FAIL rd4_req%0d: op=%0d dev=%h reg=%h, want op=%0d dev=%h reg=%h",
                         k, lg_op[s0+k], lg_dev[s0+k], lg_reg[s0+k], eop[k], edev[k], ereg[k]);
            end
        end
        checks++;
        if (lg_cyc[s0+1] - lg_cyc[s0] !== LAT + 2) begin
            errors++; $display("FAIL rd4_gap: got %0d, want %0d", lg_cyc[s0+1] - lg_cyc[s0], LAT + 2);
        end
        checks++;
        if (rd_data !== {96'h0, 32'h44332211}) begin errors++; $display("FAIL rd4_data: got %h, want 44332211", rd_data); end
        checks++;
        if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0 || err_code !== 2'd0) begin
            errors++; $display("FAIL rd4_status: done=%0d err=%0d code=%0d, want 1 0 0", done_cnt - d0, err_cnt - e0, err_code);
        end
        checks++;
        if (pulse_cyc !== lg_cyc[s0+5] + LAT + 1 || busy_fall !== pulse_cyc + 1) begin
            errors++; $display("FAIL rd4_end_timing: pulse=%0d fall=%0d, want %0d %0d",
                               pulse_cyc, busy_fall, lg_cyc[s0+5] + LAT + 1, lg_cyc[s0+5] + LAT + 2);
        end
    endtask

    task automatic test_write2();
        logic [1:0] eop  [4] = '{2'd0, 2'd2, 2'd2, 2'd0};
        logic [7:0] edev [4] = '{8'hE2, 8'hA2, 8'hA2, 8'hE2};
        logic [7:0] ereg [4] = '{8'h01, 8'h10, 8'h11, 8'h00};
        logic [7:0] ewd  [4] = '{8'h00, 8'hAA, 8'hBB, 8'h00};
        int s0, d0, e0, t0, ok;
        s0 = n_st; d0 = done_cnt; e0 = err_cnt;
        launch(1'b1, 2'd1, 3'd0, 1'b1, 8'h10, 5'd2, {112'h0, 16'hBBAA}, t0);
        wait_end(d0, e0, ok);
        checks++;
        if (ok !== 1 || n_st - s0 !== 4) begin errors++; $display("FAIL wr2_end: ok=%0d starts=%0d, want 1 4", ok, n_st - s0); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (lg_op[s0+k] !== eop[k] || lg_dev[s0+k] !== edev[k] || lg_reg[s0+k] !== ereg[k] ||
                (k == 1 || k == 2) && lg_wd[s0+k] !== ewd[k]) begin
                errors++;
                $display("FAIL wr2_req%0d: op=%0d dev=%h reg=%h wd=%h, want op=%0d dev=%h reg=%h wd=%h",
                         k, lg_op[s0+k], lg_dev[s0+k], lg_reg[s0+k], lg_wd[s0+k], eop[k], edev[k], ereg[k], ewd[k]);
            end
        end
        checks++;
        if (done_cnt - d0 !== 1 || err_code !== 2'd0 || rd_data !== 128'h0) begin
            errors++; $display("FAIL wr2_status: done=%0d code=%0d rd=%h, want 1 0 0", done_cnt - d0, err_code, rd_data);
        end
    endtask

    task automatic test_retry();
        logic [7:0] ereg [6] = '{8'h80, 8'h40, 8'h41, 8'h41, 8'h41, 8'h00};
        int s0, d0, e0, t0, ok;
        s0 = n_st; d0 = done_cnt; e0 = err_cnt;
        plan[s0+2] = 1; plan[s0+3] = 1;
        rd_mem[8'h40] = 8'h5A; rd_mem[8'h41] = 8'hC3;
        launch(1'b0, 2'd3, 3'd7, 1'b0, 8'h40, 5'd2, 128'h0, t0);
        wait_end(d0, e0, ok);
        checks++;
        if (ok !== 1 || n_st - s0 !== 6) begin errors++; $display("FAIL retry_end: ok=%0d starts=%0d, want 1 6", ok, n_st - s0); end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (lg_reg[s0+k] !== ereg[k]) begin
                errors++; $display("FAIL retry_req%0d: reg=%h, want %h", k, lg_reg[s0+k], ereg[k]);
            end
        end
        checks++;
        if (lg_cyc[s0+3] - lg_cyc[s0+2] !== LAT + 2) begin
            errors++; $display("FAIL retry_gap: got %0d, want %0d", lg_cyc[s0+3] - lg_cyc[s0+2], LAT + 2);
        end
        checks++;
        if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0 || err_code !== 2'd0 || rd_data !== {112'h0, 16'hC35A}) begin
            errors++; $display("FAIL retry_status: done=%0d err=%0d code=%0d rd=%h, want 1 0 0 c35a",
                               done_cnt - d0, err_cnt - e0, err_code, rd_data);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] ereg [4] = '{8'h02, 8'h02, 8'h02, 8'h00};
        int s0, d0, e0, t0, ok;
        s0 = n_st; d0 = done_cnt; e0 = err_cnt;
        plan[s0] = 2; plan[s0+1] = 2; plan[s0+2] = 2;
        launch(1'b0, 2'd0, 3'd1, 1'b0, 8'h00, 5'd1, 128'h0, t0);
        wait_end(d0, e0, ok);
        checks++;
        if (ok !== 1 || n_st - s0 !== 4) begin errors++; $display("FAIL tmo_end: ok=%0d starts=%0d, want 1 4", ok, n_st - s0); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (lg_reg[s0+k] !== ereg[k] || lg_op[s0+k] !== 2'd0 || lg_dev[s0+k] !== 8'hE0) begin
                errors++; $display("FAIL tmo_req%0d: op=%0d dev=%h reg=%h, want op=0 dev=e0 reg=%h",
                                   k, lg_op[s0+k], lg_dev[s0+k], lg_reg[s0+k], ereg[k]);
            end
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (lg_cyc[s0+k+1] - lg_cyc[s0+k] !== 102) begin
                errors++; $display("FAIL tmo_gap%0d: got %0d, want 102", k, lg_cyc[s0+k+1] - lg_cyc[s0+k]);
            end
        end
        checks++;
        if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0 || err_code !== 2'd2) begin
            errors++; $display("FAIL tmo_status: err=%0d done=%0d code=%0d, want 1 0 2", err_cnt - e0, done_cnt - d0, err_code);
        end
    endtask

    task automatic test_bad_request();
        logic [4:0] nbs [2] = '{5'd0, 5'd17};
        int s0, d0, e0, t0, ok;
        repeat (5) @(negedge clk);
        checks++;
        if (err_code !== 2'd2) begin errors++; $display("FAIL code_hold: got %0d, want 2", err_code); end
        for (int k = 0; k < 2; k++) begin
            s0 = n_st; d0 = done_cnt; e0 = err_cnt;
            launch(1'b0, 2'd0, 3'd0, 1'b0, 8'h00, nbs[k], 128'h0, t0);
            wait_end(d0, e0, ok);
            checks++;
            if (ok !== 1 || err_cnt - e0 !== 1 || done_cnt - d0 !== 0 || err_code !== 2'd1) begin
                errors++; $display("FAIL bad%0d_status: ok=%0d err=%0d done=%0d code=%0d, want 1 1 0 1",
                                   nbs[k], ok, err_cnt - e0, done_cnt - d0, err_code);
            end
            checks++;
            if (pulse_cyc !== t0 + 2 || busy_rise !== t0 + 1 || busy_fall !== t0 + 3) begin
                errors++; $display("FAIL bad%0d_timing: err=%0d rise=%0d fall=%0d, want %0d %0d %0d",
                                   nbs[k], pulse_cyc, busy_rise, busy_fall, t0 + 2, t0 + 1, t0 + 3);
            end
            checks++;
            if (n_st !== s0) begin errors++; $display("FAIL bad%0d_traffic: starts=%0d, want 0", nbs[k], n_st - s0); end
        end
    endtask

    task automatic test_reset_midop();
        int s0, d0, e0, t0, ok, k;
        s0 = n_st;
        plan[s0+1] = 2;
        launch(1'b0, 2'd1, 3'd2, 1'b0, 8'h30, 5'd2, 128'h0, t0);
        k = 0;
        while (n_st < s0 + 2 && k < 200) begin @(negedge clk); k++; end
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || i2c_op !== 2'd1) begin errors++; $display("FAIL mid_state: busy=%0d op=%0d, want 1 1", busy, i2c_op); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({busy, done, error, i2c_start, err_code, i2c_op, i2c_dev_adr, i2c_reg_adr, i2c_wr_dat} !== 32'h0 ||
            rd_data !== 128'h0) begin
            errors++; $display("FAIL mid_reset: ctrl/bus=%h rd=%h, want 0 0",
                               {busy, done, error, i2c_start, err_code, i2c_op, i2c_dev_adr, i2c_reg_adr, i2c_wr_dat}, rd_data);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (n_st !== s0 + 2) begin errors++; $display("FAIL mid_no_desel: starts=%0d, want 2", n_st - s0); end
        s0 = n_st; d0 = done_cnt; e0 = err_cnt;
        rd_mem[8'h07] = 8'h9E;
        launch(1'b0, 2'd0, 3'd3, 1'b1, 8'h07, 5'd1, 128'h0, t0);
        wait_end(d0, e0, ok);
        checks++;
        if (ok !== 1 || done_cnt - d0 !== 1 || n_st - s0 !== 3 || rd_data !== {120'h0, 8'h9E} || lg_dev[s0+1] !== 8'hA2) begin
            errors++; $display("FAIL mid_fresh: ok=%0d done=%0d starts=%0d rd=%h dev=%h, want 1 1 3 9e a2",
                               ok, done_cnt - d0, n_st - s0, rd_data, lg_dev[s0+1]);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin plan[i] = 0; rd_mem[i] = 8'h00; end
        reset = 1'b1; start = 1'b0; rw = 1'b0; map_sel = 1'b0; fmc_loc = 2'd0; mux_chan = 3'd0;
        start_adr = 8'h00; num_bytes = 5'd0; wr_data = 128'h0;
        test_reset();
        test_read4();
        test_write2();
        test_retry();
        test_timeout();
        test_bad_request();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
